dct_tile_scheduler: RTL and testbench
=====================================

// Module: dct_tile_scheduler
// PURPOSE
//   Sequences the combinational 8x8 dct2d datapath over a full IMG_H x IMG_W image.
//   Per tile: fetch 64 pixels from the source image RAM, assemble the packed window,
//   present it to dct2d, capture the coefficients, and stream them to the result RAM.
//   Sits between the pixel RAMs and a dct2d instance; dct2d is instantiated by the parent.
// PARAMETERS
//   N        16   pixel/coefficient width (signed)
//   IMG_W    128  image width in pixels; power of two, multiple of 8
//   IMG_H    128  image height in pixels; power of two, multiple of 8
//   DCT_LAT  0    dct2d latency in clocks (0 = combinational)
//   ADDR_W   14   RAM address width; log2(IMG_W*IMG_H)
// PORTS
//   clk       in   1        clock, rising edge
//   rst_n     in   1        synchronous active-low reset
//   start     in   1        one-cycle pulse starting a full-image pass; ignored while busy
//   busy      out  1        high from the cycle after start until done
//   done      out  1        one-cycle pulse after the last coefficient is accepted
//   rd_en     out  1        source RAM read strobe
//   rd_addr   out  ADDR_W   source address = y*IMG_W + x
//   rd_data   in   N        valid exactly 1 cycle after rd_en
//   dct_in    out  N*64     packed window to dct2d
//   dct_out   in   N*64     packed coefficients from dct2d
//   wr_valid  out  1        result word valid
//   wr_addr   out  ADDR_W   result address = y*IMG_W + x
//   wr_data   out  N        result coefficient
//   wr_ready  in   1        result RAM accepts on wr_valid & wr_ready
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; tile counters 0. Reset mid-pass aborts the pass.
//     No done is issued. The next start restarts from tile 0.
//   FSM: IDLE -start-> FETCH -> WAIT -> WRITE -> (FETCH of next tile | DONE) -> IDLE.
//   Tile order: raster order over tiles (tx fastest).
//     Within a tile, pixels are visited row-major: r = 0..7, c = 0..7.
//   Addresses: {ty,r} and {tx,c} are bit-concatenated. No multipliers.
//   FETCH (65 cycles): cycles 0..63 assert rd_en with the tile addresses back-to-back.
//     Cycle 64 has rd_en = 0 and drains the last read.
//     rd_data for pixel (r,c) is written to dct_in[(63-(r*8+c))*N +: N] (MSB-first packing).
//   WAIT (DCT_LAT+1 cycles): dct_in is held stable.
//     On the final WAIT edge, dct_out is latched into the coefficient buffer.
//   WRITE: emits 64 words, row-major.
//     Coefficient (r,c) = dct_out[(63-(r*8+c))*N +: N], i.e. the same mapping as dct_in.
//     wr_valid stays high across the 64 words.
//     The word index advances only on wr_valid & wr_ready.
//     wr_addr/wr_data are held unchanged while stalled.
//   After the 64th accept: if last tile -> DONE (done=1 for 1 cycle, busy drops the same
//     cycle), else FETCH of the next tile on the following cycle.
//   Minimum tile time with wr_ready=1: 65 + (DCT_LAT+1) + 64 cycles.
//     Full 128x128 pass with DCT_LAT=0: 256 * 130 = 33280 cycles.
//   dct_in retains the last tile after DONE.
//   start arriving in the same cycle as done is ignored.
//   Counters wrap cleanly:
//     tx wraps at IMG_W/8-1 and increments ty;
//     the pass ends at tx=IMG_W/8-1, ty=IMG_H/8-1.
// STRUCTURE
//   dct_pkg (shared): N default, TILE=8, TILE_PIX=64, state enum {IDLE,FETCH,WAIT,WRITE,DONE},
//     function win_slice(r,c) returning 63-(r*8+c).
//   Sub-module dct_window_buf: 64xN register array.
//     Indexed write port, packed N*64 read port, parallel load from dct_out.
//     Two instances: window and coefficients.
// TESTING
//   1. Full pass: src[a]=a[15:0]; loopback stub dct_out=dct_in; wr_ready=1.
//      Expect dst==src everywhere, done at cycle 33280 after start, single pulse.
//   2. Address order: tile0 reads 0..7, 128..135, ..., 896..903; tile1 starts at 8;
//      tile16 starts at 1024.
//   3. Packing: tile0 pixel(0,0)=16'h0001 appears at dct_in[1023:1008];
//      pixel(7,7)=16'h8000 appears at dct_in[15:0].
//   4. Backpressure: wr_ready random 50%. wr_addr/wr_data stable during stalls;
//      exactly 16384 unique accepts; pass length grows by the total stall cycles.
//   5. rst_n low during WRITE of tile 5: next cycle all outputs 0, IDLE, no done.
//      A start during busy is ignored. A new start restarts at rd_addr 0.
//   6. DCT_LAT=3 with a 3-stage registered loopback stub: results correct;
//      tile time is 133 cycles.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and helpers for the 8x8 DCT tile scheduler.
package dct_pkg;
  localparam int N_DEF    = 16;
  localparam int TILE     = 8;
  localparam int TILE_PIX = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    DONE
  } state_t;

  function automatic logic [5:0] win_slice(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return 6'd63 - {r, c};
  endfunction
endpackage

// File: rtl/dct_window_buf.sv
// 64 x N register window: indexed write, bulk load, packed read.
module dct_window_buf
  import dct_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [5:0]            widx,
  input  logic [N-1:0]          wdata,
  input  logic                  ld,
  input  logic [N*TILE_PIX-1:0] ldata,
  output logic [N*TILE_PIX-1:0] q
);
  localparam int IW = $clog2(N * TILE_PIX);

  logic [IW-1:0] base;

  assign base = IW'(widx) * IW'(N);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ldata;
    end else if (we) begin
      q[base +: N] <= wdata;
    end
  end
endmodule

// File: rtl/dct_tile_scheduler.sv
// Walks an image tile by tile through an external dct2d block.
module dct_tile_scheduler
  import dct_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int DCT_LAT = 0,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic [N*64-1:0]   dct_in,
  input  logic [N*64-1:0]   dct_out,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data,
  input  logic              wr_ready
);
  localparam int TXW = $clog2(IMG_W / TILE);
  localparam int TYW = $clog2(IMG_H / TILE);
  localparam int IW  = $clog2(N * TILE_PIX);
  localparam logic [TXW-1:0] TX_LAST = TXW'(IMG_W / TILE - 1);
  localparam logic [TYW-1:0] TY_LAST = TYW'(IMG_H / TILE - 1);
  localparam logic [6:0]     LAT_END = 7'(DCT_LAT);

  state_t         state;
  logic [6:0]     cnt;
  logic [TXW-1:0] tx, ntx;
  logic [TYW-1:0] ty, nty;
  logic           pv;
  logic [5:0]     pidx;
  logic [5:0]     nxt;
  logic           ld;
  logic           accept;
  logic           last_tile;
  logic [IW-1:0]  rbase;
  logic [N*64-1:0] coef;

  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [TYW-1:0] y,
    input logic [TXW-1:0] x,
    input logic [5:0]     i
  );
    return ADDR_W'({y, i[5:3], x, i[2:0]});
  endfunction

  assign nxt       = cnt[5:0] + 6'd1;
  assign accept    = wr_valid && wr_ready;
  assign last_tile = (tx == TX_LAST) && (ty == TY_LAST);
  assign ntx       = (tx == TX_LAST) ? '0 : tx + TXW'(1);
  assign nty       = (tx == TX_LAST) ? ty + TYW'(1) : ty;
  assign ld        = (state == WAIT) && (cnt == LAT_END);
  assign rbase     = IW'(win_slice(cnt[5:3], cnt[2:0])) * IW'(N);
  assign wr_data   = wr_valid ? coef[rbase +: N] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      tx       <= '0;
      ty       <= '0;
      pv       <= 1'b0;
      pidx     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
    end else begin
      // rd_data lags rd_en by one cycle; pv/pidx track that read
      pv   <= rd_en;
      pidx <= cnt[5:0];
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= FETCH;
            busy    <= 1'b1;
            tx      <= '0;
            ty      <= '0;
            cnt     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= pix_addr('0, '0, 6'd0);
          end
        end
        FETCH: begin
          cnt <= cnt + 7'd1;
          if (cnt == 7'd63) begin
            rd_en <= 1'b0;
          end else if (cnt == 7'd64) begin
            state <= WAIT;
            cnt   <= '0;
          end else begin
            rd_addr <= pix_addr(ty, tx, nxt);
          end
        end
        WAIT: begin
          cnt <= cnt + 7'd1;
          if (cnt == LAT_END) begin
            state    <= WRITE;
            cnt      <= '0;
            wr_valid <= 1'b1;
            wr_addr  <= pix_addr(ty, tx, 6'd0);
          end
        end
        WRITE: begin
          if (accept) begin
            cnt     <= {1'b0, nxt};
            wr_addr <= pix_addr(ty, tx, nxt);
            if (cnt[5:0] == 6'd63) begin
              wr_valid <= 1'b0;
              tx       <= ntx;
              ty       <= nty;
              if (last_tile) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state   <= FETCH;
                rd_en   <= 1'b1;
                rd_addr <= pix_addr(nty, ntx, 6'd0);
              end
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dct_window_buf #(.N(N)) u_win (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pv),
    .widx  (win_slice(pidx[5:3], pidx[2:0])),
    .wdata (rd_data),
    .ld    (1'b0),
    .ldata ('0),
    .q     (dct_in)
  );

  dct_window_buf #(.N(N)) u_coef (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (1'b0),
    .widx  (6'd0),
    .wdata ('0),
    .ld    (ld),
    .ldata (dct_out),
    .q     (coef)
  );
endmodule

// File: tb/tb_dct_tile_scheduler.sv
// Bench: loopback (LAT 0) and 3-stage registered stub (LAT 3) instances.
module tb_dct_tile_scheduler;
  localparam int N     = 16;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int PIX   = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start0 = 1'b0, busy0, done0, rd_en0, wr_valid0;
  logic          wr_ready0 = 1'b1;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [N-1:0]  rd_data0 = '0, wr_data0;
  logic [N*64-1:0] dct_in0, dct_out0;

  logic          start3 = 1'b0, busy3, done3, rd_en3, wr_valid3;
  logic          wr_ready3 = 1'b1;
  logic [AW-1:0] rd_addr3, wr_addr3;
  logic [N-1:0]  rd_data3 = '0, wr_data3;
  logic [N*64-1:0] dct_in3, dct_out3, s1, s2, s3;

  logic [N-1:0] src  [PIX];
  logic [N-1:0] dst0 [PIX];
  logic [N-1:0] dst3 [PIX];
  bit           hit0 [PIX];
  bit           hit3 [PIX];
  logic [AW-1:0] rdlog0 [$];

  int cmp = 0, bad = 0;
  int acc0 = 0, acc3 = 0, dup0 = 0, dup3 = 0;
  int done_cnt0 = 0, done_cnt3 = 0, stall3 = 0, stall_bad3 = 0;
  logic          pstall3 = 1'b0;
  logic [AW-1:0] paddr3 = '0;
  logic [N-1:0]  pdata3 = '0;

  always #5 clk = ~clk;

  dct_tile_scheduler #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .DCT_LAT(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .dct_in(dct_in0), .dct_out(dct_out0), .wr_valid(wr_valid0),
    .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ready(wr_ready0));

  dct_tile_scheduler #(.N(N), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .DCT_LAT(3), .ADDR_W(AW)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .dct_in(dct_in3), .dct_out(dct_out3), .wr_valid(wr_valid3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_ready(wr_ready3));

  assign dct_out0 = dct_in0;
  assign dct_out3 = s3;

  always @(posedge clk) begin
    s1 <= dct_in3;
    s2 <= s1;
    s3 <= s2;
    if (rd_en0) rd_data0 <= src[rd_addr0];
    if (rd_en3) rd_data3 <= src[rd_addr3];
  end

  always @(negedge clk) begin
    if (rd_en0) rdlog0.push_back(rd_addr0);
    if (done0) done_cnt0 <= done_cnt0 + 1;
    if (done3) done_cnt3 <= done_cnt3 + 1;
    if (wr_valid0 && wr_ready0) begin
      dst0[wr_addr0] <= wr_data0;
      acc0 <= acc0 + 1;
      if (hit0[wr_addr0]) dup0 <= dup0 + 1;
      hit0[wr_addr0] <= 1'b1;
    end
    if (wr_valid3 && wr_ready3) begin
      dst3[wr_addr3] <= wr_data3;
      acc3 <= acc3 + 1;
      if (hit3[wr_addr3]) dup3 <= dup3 + 1;
      hit3[wr_addr3] <= 1'b1;
    end
    if (wr_valid3 && !wr_ready3) stall3 <= stall3 + 1;
    if (pstall3 && (!wr_valid3 || wr_addr3 != paddr3 || wr_data3 != pdata3))
      stall_bad3 <= stall_bad3 + 1;
    pstall3 <= wr_valid3 && !wr_ready3;
    paddr3  <= wr_addr3;
    pdata3  <= wr_data3;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if ({busy0, done0, rd_en0, wr_valid0} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags0: got %b want 0000",
        {busy0, done0, rd_en0, wr_valid0});
    end
    cmp++;
    if (rd_addr0 !== '0 || wr_addr0 !== '0 || wr_data0 !== '0) begin
      bad++;
      $display("FAIL reset_buses0: rd %h wr %h data %h want 0",
        rd_addr0, wr_addr0, wr_data0);
    end
    cmp++;
    if (dct_in0 !== '0) begin
      bad++;
      $display("FAIL reset_dct_in0: got nonzero want 0");
    end
    cmp++;
    if ({busy3, done3, rd_en3, wr_valid3} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags3: got %b want 0000",
        {busy3, done3, rd_en3, wr_valid3});
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if (busy0 !== 1'b0 || rd_en0 !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start: busy %b rd_en %b want 0 0", busy0, rd_en0);
    end
  endtask

  task automatic test_full_pass();
    int n, base, d0, a0, nbad, first, k, e;
    base = rdlog0.size();
    d0 = done_cnt0;
    a0 = acc0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 40000) begin
      @(posedge clk); #1;
      n++;
    end
    cmp++;
    if (n != 33280) begin
      bad++;
      $display("FAIL pass_len0: got %0d cycles want 33280", n);
    end
    cmp++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL busy_at_done: got %b want 0", busy0);
    end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cmp++;
    if ({done0, busy0, rd_en0} !== 3'b000) begin
      bad++;
      $display("FAIL start_on_done: done/busy/rd_en %b want 000",
        {done0, busy0, rd_en0});
    end
    cmp++;
    if (done_cnt0 - d0 != 1) begin
      bad++;
      $display("FAIL done_pulses0: got %0d want 1", done_cnt0 - d0);
    end
    cmp++;
    if (acc0 - a0 != PIX || dup0 != 0) begin
      bad++;
      $display("FAIL accepts0: got %0d (dups %0d) want %0d (0)",
        acc0 - a0, dup0, PIX);
    end
    nbad = 0;
    first = -1;
    for (int a = 0; a < PIX; a++) begin
      if (dst0[a] !== N'(a)) begin
        nbad++;
        if (first < 0) first = a;
      end
    end
    cmp++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL dst_data0: %0d bad words, first at %0d, want 0", nbad, first);
    end
    cmp++;
    if (rdlog0.size() - base < PIX) begin
      bad++;
      $display("FAIL rd_count: got %0d reads want %0d", rdlog0.size() - base, PIX);
    end else begin
      nbad = 0;
      first = -1;
      k = base;
      for (int ty = 0; ty < IMG_H / 8; ty++)
        for (int tx = 0; tx < IMG_W / 8; tx++)
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
              e = (ty * 8 + r) * IMG_W + tx * 8 + c;
              if (rdlog0[k] !== AW'(e)) begin
                nbad++;
                if (first < 0) first = k - base;
              end
              k++;
            end
      cmp++;
      if (nbad != 0) begin
        bad++;
        $display("FAIL rd_order: %0d bad reads, first index %0d, want 0", nbad, first);
      end
      cmp++;
      if (rdlog0[base + 8] !== AW'(128)) begin
        bad++;
        $display("FAIL tile0_row1: got %0d want 128", rdlog0[base + 8]);
      end
      cmp++;
      if (rdlog0[base + 64] !== AW'(8)) begin
        bad++;
        $display("FAIL tile1_start: got %0d want 8", rdlog0[base + 64]);
      end
      cmp++;
      if (rdlog0[base + 1024] !== AW'(1024)) begin
        bad++;
        $display("FAIL tile16_start: got %0d want 1024", rdlog0[base + 1024]);
      end
    end
  endtask

  task automatic test_backpressure_lat3();
    int n, s0, a0, d0, nbad, first;
    s0 = stall3;
    a0 = acc3;
    d0 = done_cnt3;
    start3 = 1'b1;
    wr_ready3 = 1'($urandom);
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    while (done3 !== 1'b1 && n < 90000) begin
      wr_ready3 = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    wr_ready3 = 1'b1;
    @(posedge clk); #1;
    cmp++;
    if (n != 256 * 133 + (stall3 - s0)) begin
      bad++;
      $display("FAIL pass_len3: got %0d cycles want %0d", n,
        256 * 133 + (stall3 - s0));
    end
    cmp++;
    if (stall3 - s0 == 0) begin
      bad++;
      $display("FAIL stalls3: got 0 stall cycles want >0");
    end
    cmp++;
    if (stall_bad3 != 0) begin
      bad++;
      $display("FAIL stall_stable3: got %0d unstable cycles want 0", stall_bad3);
    end
    cmp++;
    if (acc3 - a0 != PIX || dup3 != 0) begin
      bad++;
      $display("FAIL accepts3: got %0d (dups %0d) want %0d (0)",
        acc3 - a0, dup3, PIX);
    end
    cmp++;
    if (done_cnt3 - d0 != 1) begin
      bad++;
      $display("FAIL done_pulses3: got %0d want 1", done_cnt3 - d0);
    end
    nbad = 0;
    first = -1;
    for (int a = 0; a < PIX; a++) begin
      if (dst3[a] !== N'(a)) begin
        nbad++;
        if (first < 0) first = a;
      end
    end
    cmp++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL dst_data3: %0d bad words, first at %0d, want 0", nbad, first);
    end
  endtask

  task automatic test_packing();
    logic [N*64-1:0] exp;
    int n, nbad;
    for (int a = 0; a < PIX; a++) src[a] = N'($urandom);
    src[0]   = 16'h0001;
    src[903] = 16'h8000;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        exp[(63 - (r * 8 + c)) * N +: N] = src[r * IMG_W + c];
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (wr_valid0 !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    cmp++;
    if (n != 66) begin
      bad++;
      $display("FAIL first_write_latency: got %0d want 66", n);
    end
    cmp++;
    if (dct_in0[1023:1008] !== 16'h0001) begin
      bad++;
      $display("FAIL pack_first: got %h want 0001", dct_in0[1023:1008]);
    end
    cmp++;
    if (dct_in0[15:0] !== 16'h8000) begin
      bad++;
      $display("FAIL pack_last: got %h want 8000", dct_in0[15:0]);
    end
    nbad = 0;
    for (int i = 0; i < 64; i++)
      if (dct_in0[i * N +: N] !== exp[i * N +: N]) nbad++;
    cmp++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL pack_window: %0d pixels differ want 0", nbad);
    end
    cmp++;
    if (wr_addr0 !== '0 || wr_data0 !== 16'h0001) begin
      bad++;
      $display("FAIL first_word: addr %0d data %h want 0 0001", wr_addr0, wr_data0);
    end
  endtask

  task automatic test_abort();
    int a0, n, nbad, dn, ad;
    a0 = acc0;
    n = 0;
    while (acc0 - a0 < 330 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    cmp++;
    if (wr_valid0 !== 1'b1 || wr_addr0 !== AW'(170) || wr_data0 !== src[170]) begin
      bad++;
      $display("FAIL tile5_word10: valid %b addr %0d data %h want 1 170 %h",
        wr_valid0, wr_addr0, wr_data0, src[170]);
    end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cmp++;
    if ({busy0, rd_en0, wr_valid0} !== 3'b101 || wr_addr0 !== AW'(171)) begin
      bad++;
      $display("FAIL start_while_busy: busy/rd_en/valid %b addr %0d want 101 171",
        {busy0, rd_en0, wr_valid0}, wr_addr0);
    end
    nbad = 0;
    for (int t = 0; t < 5; t++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          ad = r * IMG_W + t * 8 + c;
          if (dst0[ad] !== src[ad]) nbad++;
        end
    cmp++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL tiles0to4_data: %0d bad words want 0", nbad);
    end
    dn = done_cnt0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    cmp++;
    if ({busy0, done0, rd_en0, wr_valid0} !== 4'b0 || rd_addr0 !== '0 ||
        wr_addr0 !== '0 || wr_data0 !== '0 || dct_in0 !== '0) begin
      bad++;
      $display("FAIL abort_outputs: flags %b rd %0d wr %0d data %h want all 0",
        {busy0, done0, rd_en0, wr_valid0}, rd_addr0, wr_addr0, wr_data0);
    end
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    cmp++;
    if (done_cnt0 != dn || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: done pulses %0d busy %b want 0 0",
        done_cnt0 - dn, busy0);
    end
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cmp++;
    if (rd_en0 !== 1'b1 || rd_addr0 !== '0) begin
      bad++;
      $display("FAIL restart_addr0: rd_en %b addr %0d want 1 0", rd_en0, rd_addr0);
    end
    @(posedge clk); #1;
    cmp++;
    if (rd_en0 !== 1'b1 || rd_addr0 !== AW'(1)) begin
      bad++;
      $display("FAIL restart_addr1: rd_en %b addr %0d want 1 1", rd_en0, rd_addr0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    for (int a = 0; a < PIX; a++) src[a] = N'(a);
    fork
      test_full_pass();
      test_backpressure_lat3();
    join
    test_packing();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
